// File: rtl/name_scroll_display.sv
// Scrolls a stored character message across an 8-digit common-anode seven-segment display.
// Optional macro SCROLL_REVERSE_EN adds a dir input that lets accepted steps scroll backwards.
module name_scroll_display #(
  parameter int MSG_LEN     = 16,
  parameter int REFRESH_DIV = 100_000
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          step_clk,
  input  logic                          enable,
`ifdef SCROLL_REVERSE_EN
  input  logic                          dir,
`endif
  input  logic                          load,
  input  logic [6*MSG_LEN-1:0]          msg_chars,
  output logic [7:0]                    anodes,
  output logic [6:0]                    segments,
  output logic                          dp,
  output logic [$clog2(MSG_LEN+8)-1:0]  position
);

  localparam int L  = MSG_LEN + 8;
  localparam int PW = $clog2(L);
  localparam int IW = PW + 1;
  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] LAST_POS  = PW'(L - 1);
  localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
  localparam logic [5:0]    BLANK     = 6'd63;

  logic              s1_q, s2_q, p_q;
  logic              stepEdge;
  logic [PW-1:0]     pos_q, pos_d;
  logic [5:0]        msg_q [MSG_LEN];
  logic [5:0]        msg_d [MSG_LEN];
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2:0]        digit_q, digit_d;
  logic [7:0]        anodes_q, anodes_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q;
  logic [IW-1:0]     winIdx;
  logic [5:0]        curChar;

  function automatic logic [6:0] glyph(input logic [5:0] code);
    logic [6:0] g;
    case (code)
      6'd0:  g = 7'b1000000;
      6'd1:  g = 7'b1111001;
      6'd2:  g = 7'b0100100;
      6'd3:  g = 7'b0110000;
      6'd4:  g = 7'b0011001;
      6'd5:  g = 7'b0010010;
      6'd6:  g = 7'b0000010;
      6'd7:  g = 7'b1111000;
      6'd8:  g = 7'b0000000;
      6'd9:  g = 7'b0010000;
      6'd10: g = 7'b0001000;
      6'd11: g = 7'b0000011;
      6'd12: g = 7'b1000110;
      6'd13: g = 7'b0100001;
      6'd14: g = 7'b0000110;
      6'd15: g = 7'b0001110;
      6'd16: g = 7'b1000010;
      6'd17: g = 7'b0001001;
      6'd18: g = 7'b1111001;
      6'd19: g = 7'b1100001;
      6'd20: g = 7'b0001010;
      6'd21: g = 7'b1000111;
      6'd22: g = 7'b1101010;
      6'd23: g = 7'b0101011;
      6'd24: g = 7'b0100011;
      6'd25: g = 7'b0001100;
      6'd26: g = 7'b0011000;
      6'd27: g = 7'b0101111;
      6'd28: g = 7'b0010010;
      6'd29: g = 7'b0000111;
      6'd30: g = 7'b1000001;
      6'd31: g = 7'b1100011;
      6'd32: g = 7'b1010101;
      6'd33: g = 7'b0001001;
      6'd34: g = 7'b0010001;
      6'd35: g = 7'b0100100;
      default: g = 7'b1111111;
    endcase
    return g;
  endfunction

  always_ff @(posedge clk_in) begin
    if (reset) begin
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      p_q      <= 1'b0;
      pos_q    <= '0;
      cnt_q    <= '0;
      digit_q  <= 3'd0;
      anodes_q <= 8'hFF;
      seg_q    <= 7'h7F;
      dp_q     <= 1'b1;
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= BLANK;
    end else begin
      s1_q     <= step_clk;
      s2_q     <= s1_q;
      p_q      <= s2_q;
      pos_q    <= pos_d;
      cnt_q    <= cnt_d;
      digit_q  <= digit_d;
      anodes_q <= anodes_d;
      seg_q    <= seg_d;
      dp_q     <= 1'b1;
      for (int i = 0; i < MSG_LEN; i++) msg_q[i] <= msg_d[i];
    end
  end

  // step_clk is only data here: a synchronised rising edge becomes a one-cycle strobe.
  assign stepEdge = s2_q & ~p_q;

  always_comb begin
    pos_d = pos_q;
    for (int i = 0; i < MSG_LEN; i++) msg_d[i] = msg_q[i];
    if (load) begin
      for (int i = 0; i < MSG_LEN; i++) msg_d[i] = msg_chars[6*i +: 6];
      pos_d = '0;
    end else if (stepEdge && enable) begin
`ifdef SCROLL_REVERSE_EN
      if (dir) pos_d = (pos_q == '0) ? LAST_POS : pos_q - 1'b1;
      else     pos_d = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
`else
      pos_d = (pos_q == LAST_POS) ? '0 : pos_q + 1'b1;
`endif
    end
  end

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    digit_d = digit_q;
    if (cnt_q == LAST_CNT) begin
      cnt_d   = '0;
      digit_d = digit_q + 3'd1;
    end
  end

  // Window index never exceeds 2L-2, so a single conditional subtract implements the modulo.
  always_comb begin
    winIdx = IW'(pos_q) + IW'(3'd7 - digit_q);
    if (winIdx >= IW'(L)) winIdx = winIdx - IW'(L);
    curChar = BLANK;
    for (int i = 0; i < MSG_LEN; i++) begin
      if (winIdx == IW'(i)) curChar = msg_q[i];
    end
    anodes_d = ~(8'b1 << digit_q);
    seg_d    = glyph(curChar);
  end

  assign anodes   = anodes_q;
  assign segments = seg_q;
  assign dp       = dp_q;
  assign position = pos_q;

endmodule

// File: tb/tb_name_scroll_display.sv
// Scoreboard bench for name_scroll_display: stimulus queues expected positions and digit
// contents, a negedge monitor pops them when position or the lit anode changes.
module tb_name_scroll_display;

  localparam int MSG_LEN     = 4;
  localparam int REFRESH_DIV = 4;

  logic        clk_in    = 1'b0;
  logic        reset     = 1'b1;
  logic        step_clk  = 1'b0;
  logic        enable    = 1'b0;
  logic        load      = 1'b0;
  logic [23:0] msg_chars = '0;
`ifdef SCROLL_REVERSE_EN
  logic        dir       = 1'b0;
`endif
  logic [7:0]  anodes;
  logic [6:0]  segments;
  logic        dp;
  logic [3:0]  position;

  name_scroll_display #(.MSG_LEN(MSG_LEN), .REFRESH_DIV(REFRESH_DIV)) dut (
    .clk_in(clk_in),
    .reset(reset),
    .step_clk(step_clk),
    .enable(enable),
`ifdef SCROLL_REVERSE_EN
    .dir(dir),
`endif
    .load(load),
    .msg_chars(msg_chars),
    .anodes(anodes),
    .segments(segments),
    .dp(dp),
    .position(position)
  );

  typedef struct { logic [3:0] pos; int at; } posExp_t;
  typedef struct { logic [7:0] an; logic [6:0] seg; } dispExp_t;

  posExp_t  posQ[$];
  dispExp_t dispQ[$];
  posExp_t  pe;
  dispExp_t de;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   monOn  = 1'b0;
  bit   monInit = 1'b0;
  logic [3:0] prevPos;
  logic [7:0] prevAn;
  int   lastAnCyc;

  localparam logic [6:0] G_BLANK = 7'b1111111;
  localparam logic [6:0] G_A     = 7'b0001000;
  localparam logic [6:0] G_B     = 7'b0000011;
  localparam logic [6:0] G_C     = 7'b1000110;
  localparam logic [6:0] G_D     = 7'b0100001;
  localparam logic [6:0] G_E     = 7'b0000110;
  localparam logic [6:0] G_0     = 7'b1000000;
  localparam logic [6:0] G_1     = 7'b1111001;
  localparam logic [6:0] G_2     = 7'b0100100;

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // One step_clk pulse, high 10 cycles; an accepted step must land 3 edges after the rise.
  task automatic applyStimulus(input bit expectStep, input logic [3:0] expPos);
    @(negedge clk_in);
    step_clk = 1'b1;
    if (expectStep) posQ.push_back('{pos: expPos, at: cyc + 3});
    repeat (10) @(negedge clk_in);
    step_clk = 1'b0;
    repeat (10) @(negedge clk_in);
  endtask

  task automatic pushDisplay(input logic [6:0] d7, input logic [6:0] d6, input logic [6:0] d5,
                             input logic [6:0] d4, input logic [6:0] d3, input logic [6:0] d2,
                             input logic [6:0] d1, input logic [6:0] d0);
    dispQ.push_back('{an: 8'hFE, seg: d0});
    dispQ.push_back('{an: 8'hFD, seg: d1});
    dispQ.push_back('{an: 8'hFB, seg: d2});
    dispQ.push_back('{an: 8'hF7, seg: d3});
    dispQ.push_back('{an: 8'hEF, seg: d4});
    dispQ.push_back('{an: 8'hDF, seg: d5});
    dispQ.push_back('{an: 8'hBF, seg: d6});
    dispQ.push_back('{an: 8'h7F, seg: d7});
  endtask

  task automatic waitDrain(input int maxCyc, input string name);
    int n = 0;
    while ((posQ.size() != 0 || dispQ.size() != 0) && n < maxCyc) begin
      @(negedge clk_in);
      n++;
    end
    checkOutput({name, " drained"}, posQ.size() + dispQ.size(), 0);
    posQ.delete();
    dispQ.delete();
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " anodes"}, anodes, 8'hFF);
    checkOutput({tag, " segments"}, segments, 7'h7F);
    checkOutput({tag, " dp"}, dp, 1);
    checkOutput({tag, " position"}, position, 0);
  endtask

  // Monitor: consumes expectations only when the DUT shows a position change or a new digit.
  initial begin
    forever begin
      @(negedge clk_in);
      if (monOn) begin
        if (!monInit) begin
          prevPos   = position;
          prevAn    = anodes;
          lastAnCyc = cyc;
          monInit   = 1'b1;
        end else begin
          if (position !== prevPos) begin
            if (posQ.size() == 0) begin
              checkOutput("unexpected position change", position, prevPos);
            end else begin
              pe = posQ.pop_front();
              checkOutput("position value", position, pe.pos);
              checkOutput("position timing", cyc, pe.at);
            end
            prevPos = position;
          end
          if (anodes !== prevAn) begin
            if (anodes !== 8'hFF && prevAn !== 8'hFF) begin
              checkOutput("single anode low", $countones(~anodes), 1);
              checkOutput("digit dwell", cyc - lastAnCyc, REFRESH_DIV);
            end
            if (dispQ.size() > 0 && dispQ[0].an === anodes) begin
              de = dispQ.pop_front();
              checkOutput($sformatf("segments an=%h", anodes), segments, de.seg);
              checkOutput("dp off", dp, 1);
            end
            lastAnCyc = cyc;
            prevAn    = anodes;
          end
        end
      end
    end
  end

  initial begin
    int r;
    logic [3:0] posTab [13];
    posTab = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd0, 4'd1};

    $display("[TB] reset and refresh sweep");
    repeat (3) @(negedge clk_in);
    checkResetState("reset");
    monOn = 1'b1;
    @(negedge clk_in);
    pushDisplay(G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK);
    dispQ.push_back('{an: 8'hFE, seg: G_BLANK});
    reset = 1'b0;
    waitDrain(60, "refresh sweep");

    $display("[TB] load ABCD");
    @(negedge clk_in);
    msg_chars = {6'd13, 6'd12, 6'd11, 6'd10};
    load = 1'b1;
    @(negedge clk_in);
    load = 1'b0;
    @(negedge clk_in);
    pushDisplay(G_A, G_B, G_C, G_D, G_BLANK, G_BLANK, G_BLANK, G_BLANK);
    waitDrain(80, "ABCD display");

    $display("[TB] thirteen enabled steps");
    enable = 1'b1;
    for (int i = 0; i < 13; i++) applyStimulus(1'b1, posTab[i]);
    waitDrain(10, "enabled steps");

    $display("[TB] disabled steps");
    enable = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 4'd0);
    @(negedge clk_in);
    enable = 1'b1;
    checkOutput("position held while disabled", position, 1);
    applyStimulus(1'b1, 4'd2);
    waitDrain(10, "re-enabled step");

    $display("[TB] load colliding with step edge");
    applyStimulus(1'b1, 4'd3);
    applyStimulus(1'b1, 4'd4);
    applyStimulus(1'b1, 4'd5);
    @(negedge clk_in);
    step_clk = 1'b1;
    r = cyc;
    posQ.push_back('{pos: 4'd0, at: r + 3});
    repeat (2) @(negedge clk_in);
    msg_chars = {6'd2, 6'd1, 6'd0, 6'd14};
    load = 1'b1;
    @(negedge clk_in);
    load = 1'b0;
    @(negedge clk_in);
    pushDisplay(G_E, G_0, G_1, G_2, G_BLANK, G_BLANK, G_BLANK, G_BLANK);
    repeat (7) @(negedge clk_in);
    step_clk = 1'b0;
    repeat (10) @(negedge clk_in);
    waitDrain(80, "load collision");

    $display("[TB] reset mid-scroll");
    for (int i = 1; i <= 7; i++) applyStimulus(1'b1, 4'(i));
    waitDrain(10, "advance to 7");
    @(negedge clk_in);
    reset = 1'b1;
    load  = 1'b1;
    posQ.push_back('{pos: 4'd0, at: cyc + 1});
    @(negedge clk_in);
    checkResetState("mid-scroll reset");
    load = 1'b0;
    @(negedge clk_in);
    pushDisplay(G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK, G_BLANK);
    reset = 1'b0;
    waitDrain(80, "post-reset blank");

`ifdef SCROLL_REVERSE_EN
    $display("[TB] reverse scrolling");
    enable = 1'b1;
    dir    = 1'b1;
    applyStimulus(1'b1, 4'd11);
    applyStimulus(1'b1, 4'd10);
    waitDrain(10, "reverse steps");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
